afifo_lvl: RTL

Parametrised dual-clock FIFO that moves DATA_W-bit words from the clk_w domain to the clk_r domain using Gray-coded pointers and SYNC_STAGES-deep synchronisers. Compared with the existing basic async FIFO, it adds:
- a configurable synchroniser depth;
- a registered read-data output with a valid strobe;
- per-domain fill levels;
- programmable almost-full and almost-empty flags;
- sticky overflow and underflow error flags.

It sits between producer and consumer clock islands wherever buffering across domains is needed.

---
 rtl/afifo_lvl_if.sv | 36 +++
 rtl/afifo_lvl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/afifo_lvl_if.sv
// afifo_lvl_if: producer/consumer signal bundle for the level-reporting
// dual-clock FIFO; master drives requests, slave is the FIFO itself.
interface afifo_lvl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              push;
  logic [DATA_W-1:0] wdata;
  logic              wfull;
  logic              almost_full;
  logic [ADDR_W:0]   wr_level;
  logic              overflow;
  logic              ovf_clr;
  logic              pop;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rempty;
  logic              almost_empty;
  logic [ADDR_W:0]   rd_level;
  logic              underflow;
  logic              udf_clr;

  modport master (
    output push, wdata, ovf_clr, pop, udf_clr,
    input  wfull, almost_full, wr_level, overflow,
    input  rdata, rvalid, rempty, almost_empty,
    input  rd_level, underflow
  );

  modport slave (
    input  push, wdata, ovf_clr, pop, udf_clr,
    output wfull, almost_full, wr_level, overflow,
    output rdata, rvalid, rempty, almost_empty,
    output rd_level, underflow
  );
endinterface

// File: rtl/afifo_lvl.sv
// afifo_lvl: dual-clock Gray-pointer FIFO with registered read data,
// per-domain fill levels, almost flags and sticky error flags.
module afifo_lvl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_TH    = 12,
  parameter int AEMPTY_TH   = 2
) (
  input  logic       clk_w,
  input  logic       rst_w,
  input  logic       clk_r,
  input  logic       rst_r,
  afifo_lvl_if.slave bus
);
  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  function automatic logic [PW-1:0] g2b(
    input logic [PW-1:0] g
  );
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] rsync_q [SYNC_STAGES];
  logic [PW-1:0] rg_s, wlvl;
  logic          wfull, wen;
  logic          ovf_q, ovf_d;

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rgray_q, rgray_d;
  logic [PW-1:0] wsync_q [SYNC_STAGES];
  logic [PW-1:0] wg_s, rlvl;
  logic          rempty, ren;
  logic          udf_q, udf_d;
  logic          rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  // full: the read pointer is exactly one lap behind
  assign rg_s    = rsync_q[SYNC_STAGES-1];
  assign wfull   = wgray_q ==
    {~rg_s[PW-1:PW-2], rg_s[PW-3:0]};
  assign wen     = bus.push & ~wfull;
  assign wbin_d  = wbin_q + PW'(wen);
  assign wgray_d = wbin_d ^ (wbin_d >> 1);
  assign wlvl    = wbin_q - g2b(rg_s);

  always_comb begin
    ovf_d = ovf_q;
    if (bus.push & wfull)
      ovf_d = 1'b1;
    else if (bus.ovf_clr)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk_w or negedge rst_w) begin
    if (!rst_w) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      ovf_q   <= 1'b0;
      rsync_q <= '{default: '0};
    end else begin
      wbin_q     <= wbin_d;
      wgray_q    <= wgray_d;
      ovf_q      <= ovf_d;
      rsync_q[0] <= rgray_q;
      for (int i = 1; i < SYNC_STAGES; i++)
        rsync_q[i] <= rsync_q[i-1];
    end
  end

  always_ff @(posedge clk_w) begin
    if (wen)
      mem_q[wbin_q[ADDR_W-1:0]] <= bus.wdata;
  end

  assign wg_s    = wsync_q[SYNC_STAGES-1];
  assign rempty  = rgray_q == wg_s;
  assign ren     = bus.pop & ~rempty;
  assign rbin_d  = rbin_q + PW'(ren);
  assign rgray_d = rbin_d ^ (rbin_d >> 1);
  assign rlvl    = g2b(wg_s) - rbin_q;

  always_comb begin
    udf_d = udf_q;
    if (bus.pop & rempty)
      udf_d = 1'b1;
    else if (bus.udf_clr)
      udf_d = 1'b0;
  end

  always_ff @(posedge clk_r or negedge rst_r) begin
    if (!rst_r) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      udf_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      wsync_q  <= '{default: '0};
    end else begin
      rbin_q     <= rbin_d;
      rgray_q    <= rgray_d;
      udf_q      <= udf_d;
      rvalid_q   <= ren;
      wsync_q[0] <= wgray_q;
      for (int i = 1; i < SYNC_STAGES; i++)
        wsync_q[i] <= wsync_q[i-1];
      if (ren)
        rdata_q <= mem_q[rbin_q[ADDR_W-1:0]];
    end
  end

  assign bus.wfull        = wfull;
  assign bus.almost_full  = wlvl >= PW'(AFULL_TH);
  assign bus.wr_level     = wlvl;
  assign bus.overflow     = ovf_q;
  assign bus.rdata        = rdata_q;
  assign bus.rvalid       = rvalid_q;
  assign bus.rempty       = rempty;
  assign bus.almost_empty = rlvl <= PW'(AEMPTY_TH);
  assign bus.rd_level     = rlvl;
  assign bus.underflow    = udf_q;
endmodule
